// File: rtl/bus_pkg.sv
// Shared bus definitions: packet ID field position, default sizes and the
// transaction-type enum used by the bus environment.
package bus_pkg;

  localparam int PCKG_SZ_DFLT   = 16;
  localparam int DEEP_FIFO_DFLT = 8;

  // Destination ID lives in the top byte of a packet.
  localparam int ID_MSB = PCKG_SZ_DFLT - 1;
  localparam int ID_LSB = PCKG_SZ_DFLT - 8;

  typedef enum logic [1:0] {
    TRANS_PUSH     = 2'd0,
    TRANS_POP      = 2'd1,
    TRANS_PUSH_POP = 2'd2,
    TRANS_RESET    = 2'd3
  } tipo_trans;

endpackage

// File: rtl/bus_src_queue_if.sv
// Device/arbiter side signals of one per-device source queue.
// master: device + arbiter driving the queue; slave: the queue itself.
interface bus_src_queue_if #(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8
);
  localparam int CNT_W = $clog2(deep_fifo + 1);

  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               full;
  logic               drop;
  logic               pop;
  logic [pckg_sz-1:0] D_pop;
  logic               pndng;
  logic [CNT_W-1:0]   count;

  modport master (
    output push, D_push, pop,
    input  full, drop, D_pop, pndng, count
  );

  modport slave (
    input  push, D_push, pop,
    output full, drop, D_pop, pndng, count
  );
endinterface

// File: rtl/bus_src_queue_ram.sv
// Storage array for the source queue: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module bus_src_queue_ram #(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8,
  parameter int PTR_W     = 3
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   waddr_i,
  input  logic [pckg_sz-1:0] wdata_i,
  input  logic [PTR_W-1:0]   raddr_i,
  output logic [pckg_sz-1:0] rdata_o
);

  logic [pckg_sz-1:0] mem_q [deep_fifo];

  // Write the accepted packet into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_src_queue.sv
// First-word-fall-through per-device source queue feeding the bus arbiter.
// Optional feature: define BUS_SRC_QUEUE_OVF_CNT_EN to add the saturating
// ovf_cnt port counting discarded pushes.
module bus_src_queue
  import bus_pkg::*;
#(
  parameter int pckg_sz   = PCKG_SZ_DFLT,
  parameter int deep_fifo = DEEP_FIFO_DFLT
) (
  input  logic           clk,
  input  logic           reset,
  bus_src_queue_if.slave q
`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
  ,
  output logic [7:0]     ovf_cnt
`endif
);

  localparam int PTR_W = (deep_fifo > 1) ? $clog2(deep_fifo) : 1;
  localparam int CNT_W = $clog2(deep_fifo + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(deep_fifo);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(deep_fifo - 1);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_q, drop_d;
  logic               push_acc, pop_acc;
  logic [pckg_sz-1:0] rdata;

  // A pop on an empty queue is ignored; a push into a full queue only
  // succeeds if the head leaves in the same cycle.
  assign pop_acc  = q.pop && (count_q != '0);
  assign push_acc = q.push && ((count_q != FULL_CNT) || pop_acc);

  // Next-state for pointers, occupancy and the drop pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = q.push && !push_acc;
    if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; synchronous active-low reset empties the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of discarded pushes.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop_d && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  // Overflow counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) ovf_cnt_q <= 8'd0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  // Writes are blocked during reset so a push in that cycle leaves no trace.
  bus_src_queue_ram #(
    .pckg_sz  (pckg_sz),
    .deep_fifo(deep_fifo),
    .PTR_W    (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (push_acc && reset),
    .waddr_i(wr_ptr_q),
    .wdata_i(q.D_push),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign q.pndng = (count_q != '0);
  assign q.full  = (count_q == FULL_CNT);
  assign q.count = count_q;
  assign q.drop  = drop_q;
  assign q.D_pop = q.pndng ? rdata : '0;

endmodule

// File: tb/tb_bus_src_queue.sv
// Directed bench for bus_src_queue (depth 8, 16-bit packets).
module tb_bus_src_queue;

  localparam int PS = 16;
  localparam int DF = 8;
  localparam int CW = $clog2(DF + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_src_queue_if #(.pckg_sz(PS), .deep_fifo(DF)) qif ();

`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  bus_src_queue #(.pckg_sz(PS), .deep_fifo(DF)) dut (
    .clk  (clk),
    .reset(reset),
    .q    (qif)
`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
    ,
    .ovf_cnt(ovf_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        push;
    logic        pop;
    logic [15:0] data;
    logic        pndng;
    logic        full;
    logic [CW-1:0] count;
    logic [15:0] dpop;
    logic        drop;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic pnd, input logic fl,
                           input logic [CW-1:0] cnt, input logic [15:0] dp,
                           input logic dr);
    chk({nm, ".pndng"}, 32'(qif.pndng), 32'(pnd));
    chk({nm, ".full"},  32'(qif.full),  32'(fl));
    chk({nm, ".count"}, 32'(qif.count), 32'(cnt));
    chk({nm, ".D_pop"}, 32'(qif.D_pop), 32'(dp));
    chk({nm, ".drop"},  32'(qif.drop),  32'(dr));
  endtask

  // Drive inputs, clock once, return 1 time unit after the edge.
  task automatic step(input logic ps, input logic pp, input logic [15:0] d);
    qif.push   = ps;
    qif.pop    = pp;
    qif.D_push = d;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q [$];

  initial begin
    qif.push = 1'b0; qif.pop = 1'b0; qif.D_push = '0;
    reset = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b1;
    chk_state("reset", 0, 0, 0, 16'h0, 0);
`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
    chk("reset.ovf", 32'(ovf_cnt), 32'd0);
`endif

    // Idle with occasional pop pulses: nothing may change.
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 16'hFFFF);
      chk_state($sformatf("idle%0d", i), 0, 0, 0, 16'h0, 0);
    end

    //          push pop data     pnd full cnt dpop     drop
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0202, 1'b1, 1'b0, 4'd1, 16'h0202, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0203, 1'b1, 1'b0, 4'd2, 16'h0202, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0204, 1'b1, 1'b0, 4'd3, 16'h0202, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd2, 16'h0203, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4'd1, 16'h0204, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'h0303, 1'b1, 1'b0, 4'd1, 16'h0303, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].data);
      chk_state($sformatf("vec%0d", i), vecs[i].pndng, vecs[i].full,
                vecs[i].count, vecs[i].dpop, vecs[i].drop);
    end

    // Fill to capacity.
    for (int i = 0; i < DF; i++) begin
      step(1, 0, 16'h0100 + 16'(i));
      chk("fill.count", 32'(qif.count), 32'(i + 1));
    end
    chk_state("full", 1, 1, 4'd8, 16'h0100, 0);

    // Push into a full queue: discarded, drop pulses for one cycle.
    step(1, 0, 16'h0F0F);
    chk_state("ovf", 1, 1, 4'd8, 16'h0100, 1);
`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
    chk("ovf.cnt1", 32'(ovf_cnt), 32'd1);
`endif
    step(0, 0, 0);
    chk_state("ovf_after", 1, 1, 4'd8, 16'h0100, 0);

`ifdef BUS_SRC_QUEUE_OVF_CNT_EN
    // Saturation of the discarded-push counter.
    for (int i = 0; i < 260; i++) step(1, 0, 16'h0F0F);
    chk("ovf.sat", 32'(ovf_cnt), 32'd255);
    step(0, 0, 0);
    chk("ovf.sat_hold", 32'(ovf_cnt), 32'd255);
`endif

    // Full queue, push with simultaneous pop: accepted, no drop.
    step(1, 1, 16'h0A0A);
    chk_state("fullpp", 1, 1, 4'd8, 16'h0101, 0);

    for (int i = 1; i < DF; i++) exp_q.push_back(16'h0100 + 16'(i));
    exp_q.push_back(16'h0A0A);
    for (int i = 0; i < DF; i++) begin
      chk($sformatf("drain%0d", i), 32'(qif.D_pop), 32'(exp_q[i]));
      step(0, 1, 0);
    end
    chk_state("drained", 0, 0, 0, 16'h0, 0);

    // Push/pop pairs across pointer wrap, reset in the middle.
    for (int k = 0; k < 20; k++) begin
      if (k == 12) begin
        step(1, 0, 16'h0500 + 16'(k));
        chk("pair12.count", 32'(qif.count), 32'd1);
        reset = 1'b0;
        step(1, 1, 16'h0BAD);
        reset = 1'b1;
        chk_state("midreset", 0, 0, 0, 16'h0, 0);
      end else begin
        step(1, 0, 16'h0500 + 16'(k));
        chk($sformatf("pair%0d.push", k), 32'(qif.D_pop), 32'(16'h0500 + 16'(k)));
        step(0, 1, 0);
        chk($sformatf("pair%0d.pop", k), 32'(qif.count), 32'd0);
      end
    end

    // After reset, several packets pop in order.
    step(1, 0, 16'h0601);
    step(1, 0, 16'h0602);
    step(1, 0, 16'h0603);
    chk("post.count", 32'(qif.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post%0d", i), 32'(qif.D_pop), 32'(16'h0601 + 16'(i)));
      step(0, 1, 0);
    end
    chk_state("post_empty", 0, 0, 0, 16'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_src_queue.md
# bus_src_queue

Synthesizable per-device source queue that sits directly upstream of the bus arbiter `bs_gnrtr_n_rbtr`. One instance per device: the device pushes packets in; the arbiter sees `pndng` and pops them through `D_pop` when it grants the bus to this device. First-word-fall-through, so the head packet is always presented on `D_pop` while `pndng` is high. It replaces the behavioural queue in the bench driver, giving the RTL flow a real device-side buffer.

## Interface
- `pckg_sz`, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID, the rest is payload.
- `deep_fifo`, 8, queue depth in packets; legal range ≥ 2, need not be a power of two.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `push`  in  1  device writes `D_push` this cycle.
- `D_push`  in  pckg_sz  packet from the device.
- `full`  out  1  queue holds `deep_fifo` packets.
- `drop`  out  1  one-cycle pulse: the push in the previous cycle was discarded.
- `pop`  in  1  arbiter consumes the head packet this cycle.
- `D_pop`  out  pckg_sz  head packet; 0 when empty.
- `pndng`  out  1  queue non-empty.
- `count`  out  $clog2(deep_fifo+1)  packets currently held.
- `ovf_cnt`  out  8  saturating discarded-push count; present only with the macro in Configuration.

## Operation
- Storage: circular buffer of `deep_fifo` entries, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy `count`.
- Pointers increment by 1 and wrap from `deep_fifo-1` to 0 explicitly; no reliance on power-of-two wrap.
- Push accepted when `push` is high and (`count < deep_fifo` or `pop` is accepted in the same cycle).
- Pop accepted when `pop` is high and `count > 0`; pop on empty is ignored with no side effects.
- Push on full without a simultaneous accepted pop: data discarded, pointers and `count` unchanged, `drop` pulses.
- Push and pop both accepted: `count` unchanged, both pointers advance.
- Push and pop on empty: pop ignored, push accepted, `count` becomes 1.
- Push and pop on full: both accepted, `full` stays 1, no drop.
- `count` update: +1 on push only, −1 on pop only, unchanged otherwise; never exceeds `deep_fifo`, never below 0.
- `pndng = (count != 0)`, `full = (count == deep_fifo)`, both registered-state derived (no combinational path from `push`/`pop`).
- `D_pop = mem[rd_ptr]` when `pndng`, else 0; no path from `D_push` to `D_pop` in the same cycle.
- Packet contents are not inspected or modified.

## Timing
- Reset (low at a rising edge): `wr_ptr`, `rd_ptr`, `count` = 0; `pndng` = 0, `full` = 0, `drop` = 0, `D_pop` = 0, `ovf_cnt` = 0. Memory contents undefined and never visible.
- Reset mid-operation discards all queued packets; `push`/`pop` in the reset cycle are ignored.
- Push-to-visible latency: push accepted at edge N → `pndng` = 1 and `D_pop` = packet after edge N.
- Pop accepted at edge N → next packet (or 0 if now empty) on `D_pop` after edge N.
- `drop` asserted for exactly the cycle following the discarded push.
- Back-to-back push every cycle and pop every cycle sustains full throughput, one packet per clock.

## Configuration
- `BUS_SRC_QUEUE_OVF_CNT_EN` defined: `ovf_cnt` port and register exist; increments by 1 on every discarded push, saturates at 255, cleared only by reset.
- Not defined: no `ovf_cnt` port or register; `drop` pulse still generated.

## Structure
- Shared package `bus_pkg`: packet ID field position constants (`ID_MSB`, `ID_LSB`), default `pckg_sz`, and the `tipo_trans` enum already used by the bench.
- One sub-module: `bus_src_queue_ram`, the `deep_fifo`×`pckg_sz` storage array with one write and one asynchronous read port; pointer/count control stays in the top.

## Test plan
- Reset then idle: `pndng`=0, `full`=0, `D_pop`=0, `count`=0 for 10 cycles; `pop` pulses change nothing.
- Push 0x0202, 0x0203, 0x0204 on consecutive cycles, then pop thrice: `D_pop` shows 0x0202, 0x0203, 0x0204 in order, `pndng` drops after the third pop.
- Push 8 packets (deep_fifo=8) → `full`=1, `count`=8; ninth push 0x0F0F → `drop` pulses once, `ovf_cnt`=1 (macro on), popped data excludes 0x0F0F.
- Full queue, push 0x0A0A with pop same cycle → no drop, `full` stays 1, 0x0A0A emerges last.
- Empty queue, push 0x0303 with pop same cycle → `count`=1, `D_pop`=0x0303 next cycle.
- 20 push/pop pairs across wrap with reset asserted at pair 12 → queue empty next cycle, subsequent pushes restart from `wr_ptr`=0 and pop in order.
